// File: rtl/cv32e40p_x_if_pkg.sv
// cv32e40p_x_if_pkg: shared x-interface types and defaults.
//   x_result_t               buffered accelerator result (rd, data)
//   X_RES_FIFO_DEPTH_DEFAULT default result FIFO depth
package cv32e40p_x_if_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } x_result_t;

    localparam int X_RES_FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// cv32e40p_x_result_fifo: in-order x_result_t FIFO, async active-high reset.
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write request and entry (ignored while full)
//   pop           read request (ignored while empty)
//   head          oldest entry
//   full, empty   occupancy flags
module cv32e40p_x_result_fifo
    import cv32e40p_x_if_pkg::*;
#(
    parameter int DEPTH = X_RES_FIFO_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  x_result_t din,
    input  logic      pop,
    output x_result_t head,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    x_result_t         mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    // No push-while-full bypass: a full FIFO refuses even when popping.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign head    = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= do_push ? wptr + AW'(1) : wptr;
            rptr  <= do_pop ? rptr + AW'(1) : rptr;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/cv32e40p_x_result_wb.sv
// cv32e40p_x_result_wb: buffers x-interface results and writes them back through
// the shared RF write port whenever the core WB stage leaves it free.
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   x_result_valid/ready/rd/data/we  accelerator result channel
//   core_wb_we_i                     core WB owns the RF port this cycle (priority)
//   rf_we_o, rf_waddr_o, rf_wdata_o  accelerator RF write
//   x_rvalid_o, x_rwaddr_o           scoreboard clear to the dispatcher
//   core_stall_o                     hold core WB so a starved result can retire
//   fifo_empty_o                     no buffered results
// Optional: CV32E40P_X_RES_STARVE_GUARD_EN enables the starvation guard;
// without it core_stall_o is tied 0.
module cv32e40p_x_result_wb
    import cv32e40p_x_if_pkg::*;
#(
    parameter int DEPTH        = X_RES_FIFO_DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_result_valid_i,
    output logic        x_result_ready_o,
    input  logic [4:0]  x_result_rd_i,
    input  logic [31:0] x_result_data_i,
    input  logic        x_result_we_i,
    input  logic        core_wb_we_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        x_rvalid_o,
    output logic [4:0]  x_rwaddr_o,
    output logic        core_stall_o,
    output logic        fifo_empty_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_param
        $error("cv32e40p_x_result_wb: illegal DEPTH or STARVE_LIMIT");
    end

    x_result_t head;
    logic      full;
    logic      empty;
    logic      push;
    logic      pop;

    // Results without a register write are accepted and dropped here.
    assign push = x_result_valid_i & x_result_ready_o & x_result_we_i;
    assign pop  = ~empty & ~core_wb_we_i;

    cv32e40p_x_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .din   ('{rd: x_result_rd_i, data: x_result_data_i}),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    assign x_result_ready_o = ~full;
    assign fifo_empty_o     = empty;
    // rd=0 still clears the scoreboard but never touches x0.
    assign rf_we_o          = pop & (head.rd != 5'd0);
    assign rf_waddr_o       = pop ? head.rd : 5'd0;
    assign rf_wdata_o       = pop ? head.data : 32'd0;
    assign x_rvalid_o       = pop;
    assign x_rwaddr_o       = pop ? head.rd : 5'd0;

`ifdef CV32E40P_X_RES_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
        end else if (pop || empty) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 8'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    assign core_stall_o = ~empty & (starve_cnt == 8'(STARVE_LIMIT));
`else
    assign core_stall_o = 1'b0;
`endif

endmodule

// File: tb/tb_cv32e40p_x_result_wb.sv
// tb_cv32e40p_x_result_wb: directed self-checking bench for cv32e40p_x_result_wb.
module tb_cv32e40p_x_result_wb;

`ifdef CV32E40P_X_RES_STARVE_GUARD_EN
    localparam int LIMIT = 3;
`else
    localparam int LIMIT = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ready;
    logic [4:0]  rd = '0;
    logic [31:0] data = '0;
    logic        we = 1'b0;
    logic        core_we = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rvalid;
    logic [4:0]  rwaddr;
    logic        stall;
    logic        empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cv32e40p_x_result_wb #(.DEPTH(4), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .x_result_valid_i (valid),
        .x_result_ready_o (ready),
        .x_result_rd_i    (rd),
        .x_result_data_i  (data),
        .x_result_we_i    (we),
        .core_wb_we_i     (core_we),
        .rf_we_o          (rf_we),
        .rf_waddr_o       (rf_waddr),
        .rf_wdata_o       (rf_wdata),
        .x_rvalid_o       (rvalid),
        .x_rwaddr_o       (rwaddr),
        .core_stall_o     (stall),
        .fifo_empty_o     (empty)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] r, input logic [31:0] d, input logic w);
        valid = v;
        rd    = r;
        data  = d;
        we    = w;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        core_we = 1'b0;
        @(negedge clk);
        checks++;
        if ({ready, empty, rf_we, rvalid, stall} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 11000", {ready, empty, rf_we, rvalid, stall});
        end
        checks++;
        if ({rf_waddr, rf_wdata, rwaddr} !== 42'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {rf_waddr, rf_wdata, rwaddr});
        end
        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        checks++;
        if ({ready, empty, rf_we, rvalid} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release: got %b want 1100", {ready, empty, rf_we, rvalid});
        end
    endtask

    task automatic test_single();
        cyc();
        drive(1, 5, 32'hDEADBEEF, 1);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_no_bypass: rf_we=%b rvalid=%b want 0 0", rf_we, rvalid);
        end
        cyc();
        drive(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, rvalid, rwaddr} !== {1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5}) begin
            errors++;
            $display("FAIL single_pop: got we=%b a=%0d d=%h rv=%b ra=%0d want 1 5 deadbeef 1 5",
                     rf_we, rf_waddr, rf_wdata, rvalid, rwaddr);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_after: empty=%b rvalid=%b want 1 0", empty, rvalid);
        end
    endtask

    task automatic test_fill();
        core_we = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            drive(1, 5'(i), 32'(i * 32'h11), 1);
            @(negedge clk);
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("FAIL fill_ready_%0d: got %b want 1", i, ready);
            end
        end
        cyc();
        drive(1, 9, 32'h99, 1);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || rf_we !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: ready=%b rf_we=%b want 0 0", ready, rf_we);
        end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            drive(0, 0, 0, 0);
            core_we = 1'b0;
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== 32'(i * 32'h11) || ready !== (i != 1)) begin
                errors++;
                $display("FAIL fill_pop_%0d: we=%b a=%0d d=%h rdy=%b want 1 %0d %h %b",
                         i, rf_we, rf_waddr, rf_wdata, ready, i, i * 32'h11, i != 1);
            end
        end
        cyc();
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL fill_drained: empty=%b rvalid=%b want 1 0", empty, rvalid);
        end
    endtask

    task automatic test_rd0_and_nowe();
        cyc();
        drive(1, 0, 32'h1234, 1);
        cyc();
        drive(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b0 || rvalid !== 1'b1 || rwaddr !== 5'd0) begin
            errors++;
            $display("FAIL rd0: rf_we=%b rvalid=%b rwaddr=%0d want 0 1 0", rf_we, rvalid, rwaddr);
        end
        cyc();
        drive(1, 7, 32'h77, 0);
        @(negedge clk);
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL nowe_ready: got %b want 1", ready);
        end
        cyc();
        drive(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (rvalid !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL nowe_dropped: rvalid=%b empty=%b want 0 1", rvalid, empty);
        end
    endtask

    task automatic test_back_to_back();
        core_we = 1'b1;
        cyc();
        drive(1, 10, 32'hA0, 1);
        cyc();
        drive(1, 11, 32'hA1, 1);
        for (int k = 0; k < 10; k++) begin
            cyc();
            core_we = 1'b0;
            drive(1, 5'(12 + k), 32'(32'hA2 + k), 1);
            @(negedge clk);
            checks++;
            if (rf_waddr !== 5'(10 + k) || rf_wdata !== 32'(32'hA0 + k) || ready !== 1'b1 || empty !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d: a=%0d d=%h rdy=%b empty=%b want %0d %h 1 0",
                         k, rf_waddr, rf_wdata, ready, empty, 10 + k, 32'hA0 + k);
            end
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            drive(0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(20 + k)) begin
                errors++;
                $display("FAIL b2b_tail_%0d: we=%b a=%0d want 1 %0d", k, rf_we, rf_waddr, 20 + k);
            end
        end
        cyc();
        @(negedge clk);
        checks++;
        if (empty !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: empty=%b rvalid=%b want 1 0", empty, rvalid);
        end
    endtask

    task automatic test_guard();
        cyc();
        core_we = 1'b1;
        drive(1, 3, 32'h33, 1);
`ifdef CV32E40P_X_RES_STARVE_GUARD_EN
        for (int c = 1; c <= 3; c++) begin
            cyc();
            drive(0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (stall !== 1'b0) begin
                errors++;
                $display("FAIL guard_early_%0d: stall=%b want 0", c, stall);
            end
        end
        cyc();
        core_we = 1'b0;
        @(negedge clk);
        checks++;
        if (stall !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
            errors++;
            $display("FAIL guard_stall: stall=%b we=%b a=%0d want 1 1 3", stall, rf_we, rf_waddr);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (stall !== 1'b0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL guard_clear: stall=%b empty=%b want 0 1", stall, empty);
        end
`else
        for (int c = 1; c <= 12; c++) begin
            cyc();
            drive(0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (stall !== 1'b0 || rf_we !== 1'b0) begin
                errors++;
                $display("FAIL guard_off_%0d: stall=%b rf_we=%b want 0 0", c, stall, rf_we);
            end
        end
        cyc();
        core_we = 1'b0;
        @(negedge clk);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd3) begin
            errors++;
            $display("FAIL guard_off_pop: we=%b a=%0d want 1 3", rf_we, rf_waddr);
        end
        cyc();
`endif
    endtask

    task automatic test_async_reset();
        core_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(1, 5'(21 + i), 32'(i), 1);
        end
        cyc();
        drive(0, 0, 0, 0);
        @(negedge clk);
        core_we = 1'b0;
        #1;
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd21) begin
            errors++;
            $display("FAIL areset_pre: we=%b a=%0d want 1 21", rf_we, rf_waddr);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({ready, empty, rf_we, rvalid, stall} !== 5'b11000 || {rf_waddr, rf_wdata, rwaddr} !== 42'd0) begin
            errors++;
            $display("FAIL areset_now: flags=%b data=%h want 11000 0",
                     {ready, empty, rf_we, rvalid, stall}, {rf_waddr, rf_wdata, rwaddr});
        end
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc();
            @(negedge clk);
            checks++;
            if (empty !== 1'b1 || rf_we !== 1'b0 || rvalid !== 1'b0) begin
                errors++;
                $display("FAIL areset_after_%0d: empty=%b we=%b rv=%b want 1 0 0", c, empty, rf_we, rvalid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_rd0_and_nowe();
        test_back_to_back();
        test_guard();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_x_result_wb.md
Name: cv32e40p_x_result_wb

Overview:
- Sits downstream of the x-interface dispatcher, on the x-interface result channel.
- Buffers accelerator results (rd, data, we) in a small in-order FIFO.
- Arbitrates the single register-file write port against the core WB stage; core writeback always has priority.
- On every retired result, drives the scoreboard-clear pair (x_rvalid_o / x_rwaddr_o) consumed by the dispatcher.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- STARVE_LIMIT, 8, consecutive blocked cycles before the core is stalled; only used with the optional feature; range 1..255.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- x_result_valid_i  in  1  accelerator result valid
- x_result_ready_o  out  1  block can accept a result
- x_result_rd_i  in  5  destination register
- x_result_data_i  in  32  result data
- x_result_we_i  in  1  result carries a register write
- core_wb_we_i  in  1  core WB stage uses the RF write port this cycle
- rf_we_o  out  1  RF write enable (accelerator path)
- rf_waddr_o  out  5  RF write address
- rf_wdata_o  out  32  RF write data
- x_rvalid_o  out  1  scoreboard clear strobe to dispatcher
- x_rwaddr_o  out  5  scoreboard register to clear
- core_stall_o  out  1  request for the core to hold its WB stage
- fifo_empty_o  out  1  no buffered results

Behaviour:
- Reset values (while rst_i=1 and after it releases):
  - count=0, read/write pointers=0, starvation counter=0.
  - x_result_ready_o=1, fifo_empty_o=1.
  - rf_we_o=0, x_rvalid_o=0, core_stall_o=0.
  - rf_waddr_o=0, rf_wdata_o=0, x_rwaddr_o=0.
- Reset asserted mid-operation: all buffered entries are discarded; no partial write is issued.
- Push / handshake:
  - x_result_ready_o = ~full. No push-while-full bypass, even if a pop happens in the same cycle.
  - Handshake is valid & ready.
  - A result with we=0 is accepted and dropped: nothing is stored and x_rvalid_o is not pulsed.
- Latency:
  - A pushed entry reaches the head one cycle after the handshake. There is no combinational bypass from the result channel to the RF port.
  - Minimum latency from handshake to rf_we_o is 1 cycle.
- Pop:
  - Occurs when the head is valid and core_wb_we_i=0.
  - In the pop cycle, all outputs are combinational from the head entry: rf_we_o=1, rf_waddr_o=rd, rf_wdata_o=data, x_rvalid_o=1, x_rwaddr_o=rd.
  - Outputs are 0 when there is no pop.
- rd=0 entries: rf_we_o is suppressed (kept 0), but x_rvalid_o still pulses with x_rwaddr_o=0.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Count width is $clog2(DEPTH+1).
- full = (count==DEPTH); fifo_empty_o = (count==0).
- Ordering: strict FIFO. Two results to the same rd retire in arrival order and produce two x_rvalid_o pulses.

Optional Feature:
- Macro: CV32E40P_X_RES_STARVE_GUARD_EN.
- Defined:
  - An 8-bit counter increments each cycle the head is valid and core_wb_we_i=1.
  - The counter clears on pop or when the FIFO is empty, and saturates at STARVE_LIMIT.
  - core_stall_o = (counter==STARVE_LIMIT) & head valid.
  - The core must deassert core_wb_we_i in cycles where core_stall_o=1, so the pop occurs in that cycle.
- Undefined: core_stall_o tied 0 and the counter is absent.

Decomposition:
- Shared package cv32e40p_x_if_pkg gains:
  - typedef x_result_t (rd[4:0], data[31:0]);
  - localparam X_RES_FIFO_DEPTH_DEFAULT = 4.
- One natural sub-module, cv32e40p_x_result_fifo:
  - generic x_result_t FIFO with push/pop/full/empty/head;
  - async active-high reset.
- Arbitration, the rd=0 rule and the starvation guard stay in the top module.

Test Plan:
- Reset release, then push rd=5, data=0xDEADBEEF, core_wb_we_i=0 -> next cycle rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xDEADBEEF, x_rvalid_o=1, x_rwaddr_o=5; fifo_empty_o=1 afterwards.
- Fill path: core_wb_we_i=1 held, push 4 results rd=1..4 (DEPTH=4) -> x_result_ready_o=0 after the 4th; a 5th valid is not accepted. Release core_wb_we_i -> pops rd=1,2,3,4 on 4 consecutive cycles, ready returns to 1 after the first pop.
- Push rd=0, data=0x1234 -> rf_we_o stays 0, x_rvalid_o=1 with x_rwaddr_o=0; push with we=0 -> no x_rvalid_o pulse, count unchanged.
- Simultaneous push and pop at count=2 for 10 cycles -> count stays 2, outputs in order, pointers wrap without loss or duplication.
- Guard (macro defined, STARVE_LIMIT=3): head valid, core_wb_we_i=1 for 3 cycles -> core_stall_o=1 on cycle 4; bench drops core_wb_we_i -> pop that cycle and core_stall_o=0 next cycle. Macro undefined -> core_stall_o always 0.
- Assert rst_i asynchronously with 3 entries buffered -> all outputs take reset values immediately; after release fifo_empty_o=1 and no rf_we_o occurs.
